// File: rtl/ysyx_23060332_sram.sv
// ysyx_23060332_sram: data memory with split read/write valid-ready channels, fixed latency and alignment errors
// Ports: clk, rst_n (async, active low); AR (arvalid/arready/araddr), R (rvalid/rready/rdata/rresp),
// AW (awvalid/awready/awaddr), W (wvalid/wready/wdata/wstrb), B (bvalid/bready/bresp).
// The physical memory is a word array reached through pmem_read and the write loop below; MEM_AW sets its depth.
module ysyx_23060332_sram #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_LATENCY = 1,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int MEM_AW        = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp
);
  localparam int OFF    = $clog2(STRB_WIDTH);
  localparam int HALVES = DATA_WIDTH / 32;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  r_state_t              r_state;
  w_state_t              w_state;
  logic [31:0]           mem [2**MEM_AW];
  logic [ADDR_WIDTH-1:0] raddr, waddr;
  logic [DATA_WIDTH-1:0] wbuf;
  logic [STRB_WIDTH-1:0] sbuf;
  logic                  aw_got, w_got, aw_hs, w_hs, r_mis, w_mis, do_write;
  logic [15:0]           rcnt, wcnt;
  // Only the low 32 address bits reach memory; half h of a wide beat lives 4*h bytes higher.
  function automatic logic [MEM_AW-1:0] idx(input logic [ADDR_WIDTH-1:0] a, input int h);
    logic [31:0] p;
    p = 32'(a) + 32'(4 * h);
    return p[MEM_AW+1:2];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] pmem_read(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int h = 0; h < HALVES; h++) d[h*32+:32] = mem[idx(a, h)];
    return d;
  endfunction
  assign arready  = r_state == R_IDLE && rst_n;
  assign awready  = w_state == W_IDLE && !aw_got && rst_n;
  assign wready   = w_state == W_IDLE && !w_got && rst_n;
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign r_mis    = |raddr[OFF-1:0];
  assign w_mis    = |waddr[OFF-1:0];
  assign do_write = w_state == W_WAIT && wcnt == 16'd0 && !w_mis && rst_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= R_IDLE;
      rcnt    <= '0;
      raddr   <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          raddr   <= araddr;
          rcnt    <= 16'(READ_LATENCY - 1);
          r_state <= R_WAIT;
        end
        R_WAIT: if (rcnt == 16'd0) begin
          rvalid  <= 1'b1;
          rresp   <= r_mis ? 2'b10 : 2'b00;
          rdata   <= r_mis ? '0 : pmem_read(raddr);
          r_state <= R_RESP;
        end else rcnt <= rcnt - 16'd1;
        default: if (rready) begin
          rvalid  <= 1'b0;
          r_state <= R_IDLE;
        end
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_state <= W_IDLE;
      wcnt    <= '0;
      waddr   <= '0;
      wbuf    <= '0;
      sbuf    <= '0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) waddr <= awaddr;
          if (w_hs) begin
            wbuf <= wdata;
            sbuf <= wstrb;
          end
          // Channels are captured independently; the counter starts on the edge that completes the pair.
          if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            wcnt    <= 16'(WRITE_LATENCY - 1);
            w_state <= W_WAIT;
          end else begin
            aw_got <= aw_got || aw_hs;
            w_got  <= w_got || w_hs;
          end
        end
        W_WAIT: if (wcnt == 16'd0) begin
          bvalid  <= 1'b1;
          bresp   <= w_mis ? 2'b10 : 2'b00;
          w_state <= W_RESP;
        end else wcnt <= wcnt - 16'd1;
        default: if (bready) begin
          bvalid  <= 1'b0;
          w_state <= W_IDLE;
        end
      endcase
    end
  // Non-blocking memory update: a read completing on this same edge still sees the old word.
  always_ff @(posedge clk)
    if (do_write)
      for (int h = 0; h < HALVES; h++)
        for (int b = 0; b < 4; b++)
          if (sbuf[h*4+b]) mem[idx(waddr, h)][b*8+:8] <= wbuf[h*32+b*8+:8];
endmodule

// File: tb/tb_ysyx_23060332_sram.sv
// tb_ysyx_23060332_sram: directed and randomized checks of the split-channel memory against a word-array model
module tb_ysyx_23060332_sram;
  localparam logic [31:0] BASE = 32'h8000_0000;
  logic clk = 0, rst_n = 0;
  logic arvalid = 0, rready = 0, awvalid = 0, wvalid = 0, bready = 0;
  logic [31:0] araddr = 0, awaddr = 0, wdata = 0, rdata;
  logic [3:0] wstrb = 0;
  logic arready, rvalid, awready, wready, bvalid;
  logic [1:0] rresp, bresp;
  logic arvalid6 = 0, rready6 = 0, awvalid6 = 0, wvalid6 = 0, bready6 = 0;
  logic [31:0] araddr6 = 0, awaddr6 = 0;
  logic [63:0] wdata6 = 0, rdata6;
  logic [7:0] wstrb6 = 0;
  logic arready6, rvalid6, awready6, wready6, bvalid6;
  logic [1:0] rresp6, bresp6;
  logic [31:0] model [64];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ysyx_23060332_sram #(.READ_LATENCY(1), .WRITE_LATENCY(2), .MEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .wstrb(wstrb), .bvalid(bvalid), .bready(bready), .bresp(bresp));
  ysyx_23060332_sram #(.DATA_WIDTH(64), .READ_LATENCY(2), .WRITE_LATENCY(1), .MEM_AW(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .arvalid(arvalid6), .arready(arready6), .araddr(araddr6),
    .rvalid(rvalid6), .rready(rready6), .rdata(rdata6), .rresp(rresp6),
    .awvalid(awvalid6), .awready(awready6), .awaddr(awaddr6), .wvalid(wvalid6), .wready(wready6),
    .wdata(wdata6), .wstrb(wstrb6), .bvalid(bvalid6), .bready(bready6), .bresp(bresp6));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rd32(input logic [31:0] a, input int hold, output logic [31:0] d0, output logic [31:0] d1,
                      output logic [1:0] r);
    int n = 0;
    arvalid = 1;
    araddr = a;
    while (!arready && n < 20) begin tick(); n++; end
    chk("arready", arready, 1);
    tick();
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    chk("read_latency", n, 1);
    d0 = rdata;
    for (int i = 0; i < hold; i++) begin tick(); chk("rvalid_hold", rvalid, 1); end
    d1 = rdata;
    r = rresp;
    rready = 1;
    tick();
    rready = 0;
    chk("rvalid_clear", rvalid, 0);
  endtask
  task automatic wr32(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int awd, input int wd,
                      input int hold, output logic [1:0] r);
    logic aw_done = 0, w_done = 0, ha, hw;
    int cyc = 0, n = 0;
    awaddr = a;
    wdata = d;
    wstrb = s;
    while (!(aw_done && w_done) && cyc < 20) begin
      awvalid = !aw_done && cyc >= awd;
      wvalid = !w_done && cyc >= wd;
      if (aw_done) chk("awready_low_after_capture", awready, 0);
      if (w_done) chk("wready_low_after_capture", wready, 0);
      ha = awvalid && awready;
      hw = wvalid && wready;
      tick();
      aw_done |= ha;
      w_done |= hw;
      cyc++;
    end
    awvalid = 0;
    wvalid = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    chk("write_latency", n, 2);
    for (int i = 0; i < hold; i++) begin tick(); chk("bvalid_hold", bvalid, 1); end
    r = bresp;
    bready = 1;
    tick();
    bready = 0;
    chk("bvalid_clear", bvalid, 0);
  endtask
  task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int awd, input int wd);
    logic [1:0] r;
    logic mis = a[1:0] != 0;
    wr32(a, d, s, awd, wd, $urandom_range(0, 2), r);
    chk("bresp", r, mis ? 2'b10 : 2'b00);
    if (!mis) for (int b = 0; b < 4; b++) if (s[b]) model[a[7:2]][b*8+:8] = d[b*8+:8];
  endtask
  task automatic do_rd(input logic [31:0] a, input int hold, output logic [31:0] d);
    logic [31:0] d0;
    logic [1:0] r;
    logic mis = a[1:0] != 0;
    rd32(a, hold, d0, d, r);
    chk("rresp", r, mis ? 2'b10 : 2'b00);
    chk("rdata_first", d0, mis ? 32'h0 : model[a[7:2]]);
    chk("rdata_held", d, mis ? 32'h0 : model[a[7:2]]);
  endtask
  task automatic wr64(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s, output logic [1:0] r);
    int n = 0;
    awvalid6 = 1; awaddr6 = a; wvalid6 = 1; wdata6 = d; wstrb6 = s;
    while (!(awready6 && wready6) && n < 20) begin tick(); n++; end
    tick();
    awvalid6 = 0;
    wvalid6 = 0;
    n = 0;
    while (!bvalid6 && n < 20) begin tick(); n++; end
    chk("w64_latency", n, 1);
    r = bresp6;
    bready6 = 1;
    tick();
    bready6 = 0;
  endtask
  task automatic rd64(input logic [31:0] a, output logic [63:0] d, output logic [1:0] r);
    int n = 0;
    arvalid6 = 1;
    araddr6 = a;
    while (!arready6 && n < 20) begin tick(); n++; end
    tick();
    arvalid6 = 0;
    n = 0;
    while (!rvalid6 && n < 20) begin tick(); n++; end
    chk("r64_latency", n, 2);
    d = rdata6;
    r = rresp6;
    rready6 = 1;
    tick();
    rready6 = 0;
  endtask
  initial begin
    logic [31:0] d, a;
    logic [31:0] d0;
    logic [63:0] q;
    logic [1:0] r, rr;
    tick();
    tick();
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_readys", {arready, awready, wready, arready6, awready6, wready6}, 0);
    rst_n = 1;
    #1;
    chk("post_rst_readys", {arready, awready, wready, arready6, awready6, wready6}, 6'h3f);
    for (int i = 0; i < 64; i++) do_wr(BASE + 32'(4 * i), 32'h0, 4'hF, 0, 0);
    do_wr(BASE, 32'hDEADBEEF, 4'hF, 0, 0);
    do_rd(BASE, 3, d);
    chk("deadbeef", d, 32'hDEADBEEF);
    do_wr(BASE + 32'h10, 32'hAABBCCDD, 4'hF, 0, 0);
    do_wr(BASE + 32'h10, 32'h11223344, 4'b0101, 0, 2);
    do_rd(BASE + 32'h10, 0, d);
    chk("strobe_merge", d, 32'hAA22CC44);
    do_wr(BASE + 32'h14, 32'h55555555, 4'hF, 3, 0);
    do_wr(BASE + 32'h14, 32'h12345678, 4'h0, 1, 1);
    do_rd(BASE + 32'h14, 1, d);
    chk("zero_strobe", d, 32'h55555555);
    do_rd(BASE + 32'h2, 0, d);
    do_wr(BASE + 32'h1, 32'hFFFFFFFF, 4'hF, 0, 0);
    do_rd(BASE, 0, d);
    chk("misaligned_write_no_effect", d, 32'hDEADBEEF);
    do_wr(BASE + 32'h30, 32'h0, 4'hF, 0, 0);
    fork
      begin
        wr32(BASE + 32'h30, 32'h5, 4'hF, 0, 0, 0, r);
        chk("same_cycle_bresp", r, 0);
      end
      begin
        tick();
        rd32(BASE + 32'h30, 0, d0, d, rr);
        chk("same_cycle_old_data", d0, 32'h0);
      end
    join
    model[12] = 32'h5;
    do_rd(BASE + 32'h30, 0, d);
    chk("after_write_new_data", d, 32'h5);
    do_wr(BASE + 32'h40, 32'h600D600D, 4'hF, 0, 0);
    awvalid = 1; awaddr = BASE + 32'h40; wvalid = 1; wdata = 32'hBAD0BAD0; wstrb = 4'hF;
    tick();
    awvalid = 0;
    wvalid = 0;
    #2 rst_n = 0;
    #1;
    chk("mid_rst_readys", {arready, awready, wready}, 0);
    chk("mid_rst_bvalid", bvalid, 0);
    tick();
    tick();
    chk("rst_hold_bvalid", bvalid, 0);
    rst_n = 1;
    #1;
    chk("release_readys", {arready, awready, wready}, 3'h7);
    for (int i = 0; i < 4; i++) begin tick(); chk("no_late_bvalid", bvalid, 0); end
    do_rd(BASE + 32'h40, 0, d);
    chk("dropped_write", d, 32'h600D600D);
    for (int i = 0; i < 40; i++) begin
      a = BASE + 32'(4 * $urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a += 32'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) do_wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else do_rd(a, $urandom_range(0, 2), d);
    end
    wr64(BASE + 32'h20, 64'hCAFEBABE_11111111, 8'hFF, r);
    chk("w64_resp_full", r, 0);
    wr64(BASE + 32'h20, 64'h01234567_89ABCDEF, 8'hF0, r);
    chk("w64_resp_upper", r, 0);
    rd64(BASE + 32'h20, q, r);
    chk("r64_resp", r, 0);
    chk("r64_upper_only", q, 64'h01234567_11111111);
    wr64(BASE + 32'h24, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, r);
    chk("w64_misaligned_resp", r, 2'b10);
    rd64(BASE + 32'h24, q, r);
    chk("r64_misaligned_resp", r, 2'b10);
    chk("r64_misaligned_data", q, 0);
    rd64(BASE + 32'h20, q, r);
    chk("r64_unchanged", q, 64'h01234567_11111111);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_23060332_sram.md
Name: ysyx_23060332_sram

Overview:
Parametrised DPI-C-backed data memory, the successor to the single-cycle combinational-read memory. It has independent read and write channels, each with a valid/ready handshake, and a configurable fixed response latency. Byte strobes scale with data width, and it raises an error response on misaligned access. It sits between the LSU/IFU and simulated physical memory via pmem_read/pmem_write.

Parameters:
ADDR_WIDTH, 32, address width; only the low 32 bits are passed to DPI.
DATA_WIDTH, 32, data width; legal values are 32 or 64.
READ_LATENCY, 1, posedges from AR handshake to rvalid; must be >=1.
WRITE_LATENCY, 1, posedges from both AW and W captured to bvalid; must be >=1.
STRB_WIDTH, DATA_WIDTH/8, derived; do not override.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
arvalid  in  1  read address valid.
arready  out  1  read address ready.
araddr  in  ADDR_WIDTH  read byte address.
rvalid  out  1  read data valid.
rready  in  1  read data accepted.
rdata  out  DATA_WIDTH  read data, registered.
rresp  out  2  read response: 00 OKAY, 10 SLVERR.
awvalid  in  1  write address valid.
awready  out  1  write address ready.
awaddr  in  ADDR_WIDTH  write byte address.
wvalid  in  1  write data valid.
wready  out  1  write data ready.
wdata  in  DATA_WIDTH  write data.
wstrb  in  STRB_WIDTH  byte enables.
bvalid  out  1  write response valid.
bready  in  1  write response accepted.
bresp  out  2  write response: 00 OKAY, 10 SLVERR.

Behaviour:
- Reset, effective immediately on rst_n low: both FSMs go to IDLE and counters clear. rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00. All ready outputs are 0 while rst_n=0.
- Reset mid-operation: the outstanding transaction is dropped. No pmem_write is issued for it and no response is produced after reset releases.
- Read FSM states R_IDLE -> R_WAIT -> R_RESP.
  - arready = (state==R_IDLE) && rst_n.
  - Handshake (arvalid && arready) at posedge T: latch araddr, load counter with READ_LATENCY-1, go to R_WAIT.
  - In R_WAIT, at the posedge where the counter is 0: perform the read, register rdata/rresp, set rvalid=1, go to R_RESP. rvalid therefore first appears after posedge T+READ_LATENCY.
  - In R_RESP, rvalid, rdata and rresp stay stable until rready. On rvalid && rready, clear rvalid and go to R_IDLE.
  - arready returns the cycle after the R handshake, so there is at most one outstanding read.
- Read data:
  - DATA_WIDTH=32: one pmem_read(addr).
  - DATA_WIDTH=64: lower half = pmem_read(addr), upper half = pmem_read(addr+4).
- Write FSM states W_IDLE -> W_WAIT -> W_RESP.
  - In W_IDLE, awready and wready are each high until that channel has been captured. AW and W may arrive in either order or in the same cycle. Each is latched independently.
  - When both are captured (posedge C): load counter with WRITE_LATENCY-1, go to W_WAIT.
  - At the posedge where the counter is 0: perform the write, set bvalid=1, go to W_RESP. bvalid first appears after C+WRITE_LATENCY.
  - bvalid and bresp are held until bready. On handshake, clear bvalid and go to W_IDLE.
- Write data:
  - DATA_WIDTH=32: pmem_write(addr, wdata, {4'b0,wstrb}).
  - DATA_WIDTH=64: one call per 32-bit half, at addr and addr+4, with mask = the corresponding strobe nibble zero-extended. A half whose nibble is 0 is not written.
  - wstrb all zero gives OKAY with no DPI call.
- Alignment: addr[log2(STRB_WIDTH)-1:0] != 0 is misaligned.
  - Misaligned read: SLVERR, rdata=0, no DPI call.
  - Misaligned write: SLVERR, no DPI call.
  - Latency is unchanged for error responses.
- Ordering:
  - Read and write DPI calls occur in a single posedge process, read before write.
  - A read completing in the same cycle as a write to the same address returns the old data.
  - A read completing on any later posedge sees the new data.
- Read and write channels are otherwise fully concurrent.

Test Plan:
- READ_LATENCY=1: preload 0x80000000=0xDEADBEEF, araddr=0x80000000 handshake at T -> rvalid after T+1, rdata=0xDEADBEEF, rresp=00. With rready held low for 3 cycles, rvalid and rdata stay stable.
- AW at cycle 0, W at cycle 2, wdata=0x11223344, wstrb=0b0101 over 0xAABBCCDD at 0x80000010, WRITE_LATENCY=2 -> bvalid after cycle 4. A subsequent read returns 0xAA22CC44.
- DATA_WIDTH=64: write 0x0123456789ABCDEF with wstrb=0xF0 to 0x80000020 -> only the upper word is written (0x80000024=0x01234567). The lower word is unchanged.
- araddr=0x80000002 (32-bit) -> rresp=10, rdata=0, no pmem_read. awaddr=0x80000001 -> bresp=10, memory unchanged.
- Same-cycle read completion and write to 0x80000030 (old 0x0, new 0x5) -> read returns 0x0. A following read returns 0x5.
- rst_n low while in W_WAIT -> bvalid stays 0, no pmem_write, all readys 0 during reset. After release, awready=wready=arready=1.
